// File: rtl/fast_ring_sampler_pipe.sv
// FAST-16 ring sampler: pulls the centre and 16 radius-3 ring pixels out of a 7x7 window,
// tags each beat with coordinates/border/eol/eof, and buffers it behind an output register plus skid slot.
module fast_ring_sampler_pipe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned X_W        = $clog2(IMG_W),
  parameter int unsigned Y_W        = $clog2(IMG_H)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       s_sof,
  input  logic [49*DATA_WIDTH-1:0]   s_window,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH-1:0]      m_center,
  output logic [16*DATA_WIDTH-1:0]   m_circle,
  output logic [X_W-1:0]             m_x,
  output logic [Y_W-1:0]             m_y,
  output logic                       m_border,
  output logic                       m_eol,
  output logic                       m_eof,
  output logic                       err_sof
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    center;
    logic [16*DATA_WIDTH-1:0] circle;
    logic [X_W-1:0]           x;
    logic [Y_W-1:0]           y;
    logic                     border;
    logic                     eol;
    logic                     eof;
  } beat_t;

  // Flat window index r*7+c of ring pixel k, clockwise from the top.
  localparam int unsigned RING_IDX [16] = '{3, 4, 12, 20, 27, 34, 40, 46,
                                            45, 44, 36, 28, 21, 14, 8, 2};

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [X_W-1:0] X_HI   = X_W'(IMG_W - 4);
  localparam logic [X_W-1:0] X_LO   = X_W'(3);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);
  localparam logic [Y_W-1:0] Y_HI   = Y_W'(IMG_H - 4);
  localparam logic [Y_W-1:0] Y_LO   = Y_W'(3);

  logic [16*DATA_WIDTH-1:0] ring;
  logic [X_W-1:0]           cnt_x, tag_x, nxt_x;
  logic [Y_W-1:0]           cnt_y, tag_y, nxt_y;
  logic                     expect_sof, wrap, sof_err, accept;
  beat_t                    in_beat, out_q, skid_q;
  logic                     out_valid, skid_full;

  for (genvar k = 0; k < 16; k++) begin : g_ring
    assign ring[k*DATA_WIDTH +: DATA_WIDTH] = s_window[RING_IDX[k]*DATA_WIDTH +: DATA_WIDTH];
  end

  assign s_ready = !skid_full;
  assign accept  = s_valid && s_ready;

  always_comb begin
    tag_x   = s_sof ? '0 : cnt_x;
    tag_y   = s_sof ? '0 : cnt_y;
    wrap    = (tag_x == X_LAST) && (tag_y == Y_LAST);
    sof_err = s_sof ? ((cnt_x != '0) || (cnt_y != '0)) : expect_sof;
    nxt_x   = tag_x + X_W'(1);
    nxt_y   = tag_y;
    if (tag_x == X_LAST) begin
      nxt_x = '0;
      nxt_y = (tag_y == Y_LAST) ? '0 : tag_y + Y_W'(1);
    end
    in_beat        = '0;
    in_beat.center = s_window[24*DATA_WIDTH +: DATA_WIDTH];
    in_beat.circle = ring;
    in_beat.x      = tag_x;
    in_beat.y      = tag_y;
    in_beat.border = (tag_x < X_LO) || (tag_x > X_HI) || (tag_y < Y_LO) || (tag_y > Y_HI);
    in_beat.eol    = (tag_x == X_LAST);
    in_beat.eof    = (tag_x == X_LAST) && (tag_y == Y_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_full  <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
      cnt_x      <= '0;
      cnt_y      <= '0;
      expect_sof <= 1'b1;
      err_sof    <= 1'b0;
    end else begin
      err_sof <= accept && sof_err;
      if (accept) begin
        cnt_x      <= nxt_x;
        cnt_y      <= nxt_y;
        expect_sof <= wrap;
      end
      // Output slot free or draining: refill from skid first (s_ready is low then), else from input.
      if (!out_valid || m_ready) begin
        if (skid_full) begin
          out_q     <= skid_q;
          out_valid <= 1'b1;
          skid_full <= 1'b0;
        end else if (accept) begin
          out_q     <= in_beat;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_q    <= in_beat;
        skid_full <= 1'b1;
      end
    end
  end

  assign m_valid  = out_valid;
  assign m_center = out_q.center;
  assign m_circle = out_q.circle;
  assign m_x      = out_q.x;
  assign m_y      = out_q.y;
  assign m_border = out_q.border;
  assign m_eol    = out_q.eol;
  assign m_eof    = out_q.eof;

endmodule

// File: tb/tb_fast_ring_sampler_pipe.sv
// Directed scoreboard bench for fast_ring_sampler_pipe on an 8x8 image.
module tb_fast_ring_sampler_pipe;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 8;

  logic            clk, rst;
  logic            s_valid, s_ready, s_sof;
  logic [49*DW-1:0] s_window;
  logic            m_valid, m_ready;
  logic [DW-1:0]   m_center;
  logic [16*DW-1:0] m_circle;
  logic [2:0]      m_x;
  logic [2:0]      m_y;
  logic            m_border, m_eol, m_eof, err_sof;

  fast_ring_sampler_pipe #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_window(s_window),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_center(m_center), .m_circle(m_circle), .m_x(m_x), .m_y(m_y),
    .m_border(m_border), .m_eol(m_eol), .m_eof(m_eof), .err_sof(err_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    logic [7:0]  center;
    logic [127:0] ring;
    logic        border;
    logic        eol;
    logic        eof;
  } exp_t;

  int RR [16] = '{0, 0, 1, 2, 3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0};
  int RC [16] = '{3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0, 0, 0, 1, 2};

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   mx = 0, my = 0;
  bit   mexp = 1'b1;
  int   cur_seed = 0;
  int   acc_cnt = 0;
  bit   count_tags = 1'b0;
  int   nb0 = 0, neol = 0, neof = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [49*DW-1:0] mkwin(input int seed);
    logic [49*DW-1:0] w;
    w = '0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        w[(r*7+c)*DW +: DW] = 8'(r*7 + c + seed);
    return w;
  endfunction

  task automatic set_in(input bit v, input bit sof, input int seed);
    s_valid  = v;
    s_sof    = sof;
    cur_seed = seed;
    s_window = mkwin(seed);
  endtask

  // One clock: score the output transfer and the input accept seen before the edge.
  task automatic cycle();
    bit   acc, xfer, exp_err;
    exp_t e;
    int   tx, ty;
    acc     = s_valid && s_ready;
    xfer    = m_valid && m_ready;
    exp_err = 1'b0;
    if (xfer) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 1'b1, 1'b0);
      end else begin
        e = q.pop_front();
        chk("x", m_x, e.x);
        chk("y", m_y, e.y);
        chk("center", m_center, e.center);
        chk("circle", m_circle, e.ring);
        chk("border", m_border, e.border);
        chk("eol", m_eol, e.eol);
        chk("eof", m_eof, e.eof);
        if (count_tags) begin
          if (!m_border) nb0++;
          if (m_eol) neol++;
          if (m_eof) neof++;
        end
      end
    end
    if (acc) begin
      tx = s_sof ? 0 : mx;
      ty = s_sof ? 0 : my;
      exp_err  = s_sof ? (mx != 0 || my != 0) : mexp;
      e.x      = tx;
      e.y      = ty;
      e.center = 8'(24 + cur_seed);
      for (int k = 0; k < 16; k++) e.ring[k*8 +: 8] = 8'(RR[k]*7 + RC[k] + cur_seed);
      e.border = (tx < 3) || (tx > W-4) || (ty < 3) || (ty > H-4);
      e.eol    = (tx == W-1);
      e.eof    = (tx == W-1) && (ty == H-1);
      q.push_back(e);
      mexp = (tx == W-1) && (ty == H-1);
      if (tx == W-1) begin
        mx = 0;
        my = (ty == H-1) ? 0 : ty + 1;
      end else begin
        mx = tx + 1;
        my = ty;
      end
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    chk("err_sof", err_sof, exp_err);
    if (acc) chk("m_valid_after_acc", m_valid, 1'b1);
  endtask

  task automatic drain();
    s_valid = 1'b0;
    s_sof   = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) cycle();
    chk("drained", q.size(), 0);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    mx = 0;
    my = 0;
    mexp = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] snap_ring;
    logic [15:0]  snap_tag;
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_window = '0; m_ready = 1'b0;
    @(posedge clk);
    do_reset();
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_err_sof", err_sof, 1'b0);
    chk("rst_m_center", m_center, 8'd0);
    chk("rst_m_xy", {m_x, m_y}, 6'd0);

    // Full 8x8 frame, constant window pattern, m_ready held high.
    m_ready    = 1'b1;
    count_tags = 1'b1;
    for (int i = 0; i < W*H; i++) begin
      set_in(1'b1, i == 0, 0);
      cycle();
    end
    drain();
    count_tags = 1'b0;
    chk("inner_beats", nb0, 4);
    chk("eol_beats", neol, 8);
    chk("eof_beats", neof, 1);

    // Backpressure mid-line.
    set_in(1'b1, 1'b1, acc_cnt);
    cycle();
    for (int i = 0; i < 9; i++) begin
      set_in(1'b1, 1'b0, acc_cnt);
      cycle();
    end
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 1'b0, acc_cnt);
      chk("stall_s_ready", s_ready, i == 0);
      snap_ring = m_circle;
      snap_tag  = {m_center, 1'b0, m_x, m_y, m_border};
      cycle();
      chk("stall_ring_stable", m_circle, snap_ring);
      chk("stall_tag_stable", {m_center, 1'b0, m_x, m_y, m_border}, snap_tag);
    end
    chk("held_beats", q.size(), 2);
    m_ready = 1'b1;
    set_in(1'b1, 1'b0, acc_cnt);
    cycle();
    chk("release_s_ready", s_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 1'b0, acc_cnt);
      cycle();
    end
    drain();

    // m_ready toggling with continuous input.
    for (int i = 0; i < 24; i++) begin
      m_ready = (i % 2 == 0);
      set_in(1'b1, 1'b0, acc_cnt);
      cycle();
    end
    drain();

    // Early frame start at beat 20 of a frame.
    set_in(1'b1, 1'b1, acc_cnt);
    cycle();
    for (int i = 1; i < 20; i++) begin
      set_in(1'b1, 1'b0, acc_cnt);
      cycle();
    end
    set_in(1'b1, 1'b1, acc_cnt);
    cycle();
    chk("early_sof_err", err_sof, 1'b1);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, acc_cnt);
      cycle();
    end
    drain();

    // Reset with both output and skid registers occupied.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, acc_cnt);
      cycle();
    end
    chk("full_s_ready", s_ready, 1'b0);
    chk("full_m_valid", m_valid, 1'b1);
    do_reset();
    chk("rst2_m_valid", m_valid, 1'b0);
    chk("rst2_s_ready", s_ready, 1'b1);
    m_ready = 1'b1;
    set_in(1'b1, 1'b0, acc_cnt);
    cycle();
    chk("missing_sof_err", err_sof, 1'b1);
    chk("post_rst_xy", {m_x, m_y}, 6'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
